// File: rtl/seq_mult_unit_pkg.sv
// Shared definitions for the sequential multiplier slice.
//   DEF_WIDTH : default operand width (product is 2*WIDTH bits)
//   state_t   : FSM state encoding (IDLE/CALC/SIGN/DONE)
//   cnt_width : iteration counter width, clog2(WIDTH)+1
package seq_mult_unit_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_unit_cla.sv
// Carry-lookahead adder built from 4-bit lookahead carry cells.
// cla_carry4  : 4-bit lookahead carry cell
//   p, g      : per-bit propagate / generate
//   cin       : carry into bit 0 of the group
//   c         : carries into bits 1..3 of the group
//   gg, pg    : group generate / group propagate
// cla_adder_w : WIDTH-bit adder (WIDTH multiple of 4)
//   a, b, cin : operands and carry-in
//   sum, cout : result and carry-out
module cla_carry4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [2:0] c,
    output logic       gg,
    output logic       pg
);
    always_comb begin
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        pg   = &p;
    end
endmodule

module cla_adder_w #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned NG = WIDTH / 4;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] bit_c;   // carry into each bit
    logic [NG:0]      grp_c;   // carry into each 4-bit group

    assign p        = a ^ b;
    assign g        = a & b;
    assign grp_c[0] = cin;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        logic [2:0] c_in_grp;
        logic       gg;
        logic       pg;

        cla_carry4 u_cell (
            .p   (p[4*gi +: 4]),
            .g   (g[4*gi +: 4]),
            .cin (grp_c[gi]),
            .c   (c_in_grp),
            .gg  (gg),
            .pg  (pg)
        );

        assign bit_c[4*gi +: 4] = {c_in_grp, grp_c[gi]};
        assign grp_c[gi+1]      = gg | (pg & grp_c[gi]);
    end

    assign sum  = p ^ bit_c;
    assign cout = grp_c[NG];
endmodule

// File: rtl/seq_mult_unit.sv
// Radix-2 shift-add multiplier for MIPS mult/multu.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : request a multiply (sampled only in IDLE)
//   is_signed    : 1 = two's complement, 0 = unsigned
//   a, b         : multiplicand / multiplier
//   busy         : high in CALC, SIGN, DONE
//   done         : one-cycle pulse when hi/lo are updated
//   hi, lo       : product halves, held until the next result
module seq_mult_unit
    import seq_mult_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = cnt_width(WIDTH);

    state_t            state_q, state_d;
    logic              neg_q;
    logic [WIDTH-1:0]  m_q;
    logic [WIDTH-1:0]  q_q;
    logic [WIDTH-1:0]  acc_q;
    logic [CW-1:0]     cnt_q;
    logic              done_q;
    logic [WIDTH-1:0]  hi_q, lo_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH-1:0] prod;
    logic               last_iter;

    assign addend    = q_q[0] ? m_q : '0;
    assign prod      = {acc_q, q_q};
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    cla_adder_w #(.WIDTH(WIDTH)) u_add (
        .a    (acc_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_iter) state_d = SIGN;
            SIGN:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neg_q  <= 1'b0;
            m_q    <= '0;
            q_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    // -2^(W-1) negates to itself, which reads correctly as unsigned
                    m_q   <= (is_signed && a[WIDTH-1]) ? -a : a;
                    q_q   <= (is_signed && b[WIDTH-1]) ? -b : b;
                    acc_q <= '0;
                    cnt_q <= '0;
                end
                CALC: begin
                    // {cout,sum,Q} >> 1; the accumulator's top bit is always zero
                    // after the shift, so it is not stored
                    acc_q <= {cout, sum[WIDTH-1:1]};
                    q_q   <= {sum[0], q_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + CW'(1);
                end
                SIGN: if (neg_q) {acc_q, q_q} <= -prod;
                DONE: begin
                    hi_q   <= acc_q;
                    lo_q   <= q_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
